// File: rtl/bandit_pkg.sv
// rtl/bandit_pkg.sv - shared state encodings, widths and timing defaults for bandit_ctrl
package bandit_pkg;

  localparam int STATE_W  = 4;
  localparam int CREDIT_W = 7;
  localparam int PAYOUT_W = 4;
  localparam int SEC_W    = 8;

  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_SCAN_DIV     = 100_000;
  localparam int DEF_GAME_MAX_S   = 10;
  localparam int DEF_SCORE_HOLD_S = 3;
  localparam int DEF_ERR_HOLD_S   = 2;
  localparam int DEF_CREDIT_MAX   = 99;
  localparam int IDLE_RETURN_S    = 30;

  typedef enum logic [STATE_W-1:0] {
    ST_WELCOME = 4'd0,
    ST_GAME    = 4'd1,
    ST_SCORE   = 4'd2,
    ST_ERROR   = 4'd3,
    ST_COIN    = 4'd4
  } state_t;

  function automatic logic [CREDIT_W-1:0] sat_add(
    input logic [CREDIT_W-1:0] a,
    input logic [CREDIT_W-1:0] b,
    input logic [CREDIT_W-1:0] max_val
  );
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/bandit_ctrl_sec_timer.sv
// rtl/bandit_ctrl_sec_timer.sv - one-second tick and saturating seconds count, cleared on state entry
module sec_timer
  import bandit_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             tick,
  output logic [SEC_W-1:0] sec
);

  localparam int CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CYC_W-1:0] cyc;

  // tick marks the last cycle of each second, so "sec == N-1 && tick" is exactly N seconds
  assign tick = (cyc == CYC_W'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc <= '0;
      sec <= '0;
    end else if (tick) begin
      cyc <= '0;
      if (sec != '1) sec <= sec + 1'b1;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

endmodule

// File: rtl/bandit_ctrl.sv
// rtl/bandit_ctrl.sv - slot-machine game/credit controller with display scan; BANDIT_IDLE_RETURN_EN adds COIN idle return
module bandit_ctrl
  import bandit_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int GAME_MAX_S   = DEF_GAME_MAX_S,
  parameter int SCORE_HOLD_S = DEF_SCORE_HOLD_S,
  parameter int ERR_HOLD_S   = DEF_ERR_HOLD_S,
  parameter int CREDIT_MAX   = DEF_CREDIT_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic                start,
  input  logic                stop,
  input  logic [PAYOUT_W-1:0] payout,
  output logic [STATE_W-1:0]  cur_state,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          refresh,
  output logic                ref_sign,
  output logic                st_enter
);

  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_MAX);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                timer_clr, tick;
  logic [SEC_W-1:0]    sec;
  logic                game_done, score_done, err_done;
  logic [SCAN_W-1:0]   scan_cnt, scan_nxt;

  sec_timer #(.CLK_HZ(CLK_HZ)) u_sec_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick),
    .sec  (sec)
  );

  assign game_done  = tick && (sec == SEC_W'(GAME_MAX_S - 1));
  assign score_done = tick && (sec == SEC_W'(SCORE_HOLD_S - 1));
  assign err_done   = tick && (sec == SEC_W'(ERR_HOLD_S - 1));

`ifdef BANDIT_IDLE_RETURN_EN
  logic idle_done;
  assign idle_done = tick && (sec == SEC_W'(IDLE_RETURN_S - 1));
  // any coin/start activity in COIN restarts the idle window
  assign timer_clr = (state_d != state_q) || ((state_q == ST_COIN) && (coin || start));
`else
  assign timer_clr = (state_d != state_q);
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    case (state_q)
      ST_WELCOME: begin
        if (coin) begin
          state_d  = ST_COIN;
          credit_d = sat_add(credit, CREDIT_W'(1), CMAX);
        end else if (start) begin
          state_d = ST_ERROR;
        end
      end
      ST_COIN: begin
        if (coin && start) begin
          state_d = ST_GAME;
        end else if (coin) begin
          credit_d = sat_add(credit, CREDIT_W'(1), CMAX);
        end else if (start) begin
          if (credit != '0) begin
            state_d  = ST_GAME;
            credit_d = credit - 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
`ifdef BANDIT_IDLE_RETURN_EN
        else if (idle_done) begin
          state_d = ST_WELCOME;
        end
`endif
      end
      ST_GAME: begin
        if (stop || game_done) state_d = ST_SCORE;
      end
      ST_SCORE: begin
        if (st_enter) credit_d = sat_add(credit, CREDIT_W'(payout), CMAX);
        if (score_done) state_d = (credit_d != '0) ? ST_COIN : ST_WELCOME;
      end
      ST_ERROR: begin
        if (err_done) state_d = ST_WELCOME;
      end
      default: state_d = ST_WELCOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WELCOME;
      credit   <= '0;
      st_enter <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit   <= credit_d;
      st_enter <= (state_d != state_q);
    end
  end

  assign cur_state = state_q;

  // ref_sign is registered from the next count so it is high exactly while the count is SCAN_DIV-1
  assign scan_nxt = (scan_cnt == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      ref_sign <= 1'b0;
      refresh  <= 2'd0;
    end else begin
      scan_cnt <= scan_nxt;
      ref_sign <= (scan_nxt == SCAN_W'(SCAN_DIV - 1));
      if (ref_sign) refresh <= refresh + 2'd1;
    end
  end

endmodule

// File: tb/tb_bandit_ctrl.sv
// tb/tb_bandit_ctrl.sv - self-checking bench for bandit_ctrl with directed scenarios and a random reference-model run
module tb_bandit_ctrl;

  localparam int HZ   = 10;
  localparam int SD   = 4;
  localparam int CMAX = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] payout = 4'd0;
  logic [3:0] cur_state;
  logic [6:0] credit;
  logic [1:0] refresh;
  logic       ref_sign, st_enter;

  int vectors = 0;
  int miscompares = 0;

  bandit_ctrl #(.CLK_HZ(HZ), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .stop(stop), .payout(payout),
    .cur_state(cur_state), .credit(credit), .refresh(refresh), .ref_sign(ref_sign), .st_enter(st_enter)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  cr;
    logic        en;
    logic [31:0] el;
  } mstate_t;

  mstate_t m = '0;
  int      m_scan = 0;

  // reference: state rules applied to "cycles since entry" and "cycles since reset"
  function automatic mstate_t model_next(input mstate_t cur, input logic c, s, p, input logic [3:0] pay);
    mstate_t    r;
    int         cr;
    logic [3:0] ns;
    cr = int'(cur.cr);
    ns = cur.st;
    case (cur.st)
      4'd0: if (c) begin ns = 4'd4; cr = (cr + 1 > CMAX) ? CMAX : cr + 1; end
            else if (s) ns = 4'd3;
      4'd4: begin
        if (c && s) ns = 4'd1;
        else if (c) cr = (cr + 1 > CMAX) ? CMAX : cr + 1;
        else if (s) begin
          if (cr >= 1) begin ns = 4'd1; cr = cr - 1; end
          else ns = 4'd3;
        end
`ifdef BANDIT_IDLE_RETURN_EN
        else if (int'(cur.el) + 1 == 30 * HZ) ns = 4'd0;
`endif
      end
      4'd1: if (p || int'(cur.el) + 1 == 10 * HZ) ns = 4'd2;
      4'd2: begin
        if (cur.en) cr = (cr + int'(pay) > CMAX) ? CMAX : cr + int'(pay);
        if (int'(cur.el) + 1 == 3 * HZ) ns = (cr > 0) ? 4'd4 : 4'd0;
      end
      4'd3: if (int'(cur.el) + 1 == 2 * HZ) ns = 4'd0;
      default: ns = 4'd0;
    endcase
    r.st = ns;
    r.cr = 7'(cr);
    r.en = (ns != cur.st);
    r.el = (r.en || (cur.st == 4'd4 && (c || s))) ? 32'd0 : cur.el + 32'd1;
    return r;
  endfunction

  always @(posedge clk) begin
    m      <= rst ? '0 : model_next(m, coin, start, stop, payout);
    m_scan <= rst ? 0 : m_scan + 1;
  end

  task automatic step(input logic c, input logic s, input logic p);
    coin = c; start = s; stop = p;
    @(posedge clk);
    @(negedge clk);
    coin = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (cur_state !== 4'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", cur_state); end
    vectors++; if (credit !== 7'd0) begin miscompares++; $display("FAIL rst_credit: got %0d want 0", credit); end
    vectors++; if ({refresh, ref_sign, st_enter} !== 4'b0) begin miscompares++; $display("FAIL rst_outs: got refresh=%0d ref_sign=%0d st_enter=%0d want 0", refresh, ref_sign, st_enter); end
    rst = 1'b0;
    step(0, 0, 0);
    vectors++; if ({cur_state, st_enter} !== {4'd0, 1'b0}) begin miscompares++; $display("FAIL post_rst: got state=%0d st_enter=%0d want 0/0", cur_state, st_enter); end
    step(1, 0, 0);
    vectors++; if ({cur_state, credit, st_enter} !== {4'd4, 7'd1, 1'b1}) begin miscompares++; $display("FAIL first_coin: got state=%0d credit=%0d st_enter=%0d want 4/1/1", cur_state, credit, st_enter); end
  endtask

  task automatic test_game_score;
    payout = 4'd5;
    step(0, 1, 0);
    vectors++; if ({cur_state, credit, st_enter} !== {4'd1, 7'd0, 1'b1}) begin miscompares++; $display("FAIL start_game: got state=%0d credit=%0d st_enter=%0d want 1/0/1", cur_state, credit, st_enter); end
    step(1, 1, 0);
    vectors++; if ({cur_state, credit} !== {4'd1, 7'd0}) begin miscompares++; $display("FAIL game_ignore: got state=%0d credit=%0d want 1/0", cur_state, credit); end
    step(0, 0, 1);
    vectors++; if ({cur_state, st_enter} !== {4'd2, 1'b1}) begin miscompares++; $display("FAIL stop_score: got state=%0d st_enter=%0d want 2/1", cur_state, st_enter); end
    step(0, 0, 0);
    vectors++; if (credit !== 7'd5) begin miscompares++; $display("FAIL payout_add: got %0d want 5", credit); end
    repeat (28) step(0, 0, 0);
    vectors++; if (cur_state !== 4'd2) begin miscompares++; $display("FAIL score_hold_29: got %0d want 2", cur_state); end
    step(0, 0, 0);
    vectors++; if ({cur_state, credit, st_enter} !== {4'd4, 7'd5, 1'b1}) begin miscompares++; $display("FAIL score_to_coin: got state=%0d credit=%0d st_enter=%0d want 4/5/1", cur_state, credit, st_enter); end
  endtask

  task automatic test_error;
    do_reset(2);
    step(0, 1, 0);
    vectors++; if ({cur_state, st_enter} !== {4'd3, 1'b1}) begin miscompares++; $display("FAIL start_no_credit: got state=%0d st_enter=%0d want 3/1", cur_state, st_enter); end
    step(1, 0, 0);
    vectors++; if ({cur_state, credit} !== {4'd3, 7'd0}) begin miscompares++; $display("FAIL err_coin_ignored: got state=%0d credit=%0d want 3/0", cur_state, credit); end
    repeat (18) step(0, 0, 0);
    vectors++; if (cur_state !== 4'd3) begin miscompares++; $display("FAIL err_hold_19: got %0d want 3", cur_state); end
    step(0, 0, 0);
    vectors++; if ({cur_state, st_enter} !== {4'd0, 1'b1}) begin miscompares++; $display("FAIL err_to_welcome: got state=%0d st_enter=%0d want 0/1", cur_state, st_enter); end
  endtask

  task automatic test_simultaneous;
    do_reset(1);
    step(1, 1, 0);
    vectors++; if ({cur_state, credit} !== {4'd4, 7'd1}) begin miscompares++; $display("FAIL welcome_coin_start: got state=%0d credit=%0d want 4/1", cur_state, credit); end
    step(1, 1, 0);
    vectors++; if ({cur_state, credit} !== {4'd1, 7'd1}) begin miscompares++; $display("FAIL coin_coin_start: got state=%0d credit=%0d want 1/1", cur_state, credit); end
  endtask

  task automatic test_saturation;
    do_reset(1);
    repeat (99) step(1, 0, 0);
    vectors++; if ({cur_state, credit} !== {4'd4, 7'd99}) begin miscompares++; $display("FAIL credit_99: got state=%0d credit=%0d want 4/99", cur_state, credit); end
    step(1, 0, 0);
    vectors++; if (credit !== 7'd99) begin miscompares++; $display("FAIL coin_sat: got %0d want 99", credit); end
    step(0, 1, 0);
    vectors++; if ({cur_state, credit} !== {4'd1, 7'd98}) begin miscompares++; $display("FAIL start_dec: got state=%0d credit=%0d want 1/98", cur_state, credit); end
    payout = 4'd9;
    step(0, 0, 1);
    step(0, 0, 0);
    vectors++; if ({cur_state, credit} !== {4'd2, 7'd99}) begin miscompares++; $display("FAIL payout_sat: got state=%0d credit=%0d want 2/99", cur_state, credit); end
  endtask

  task automatic test_game_timeout_rst;
    do_reset(1);
    payout = 4'd3;
    step(1, 0, 0);
    step(0, 1, 0);
    vectors++; if ({cur_state, st_enter} !== {4'd1, 1'b1}) begin miscompares++; $display("FAIL game_entry: got state=%0d st_enter=%0d want 1/1", cur_state, st_enter); end
    repeat (99) step(0, 0, 0);
    vectors++; if (cur_state !== 4'd1) begin miscompares++; $display("FAIL game_99: got %0d want 1", cur_state); end
    step(0, 0, 0);
    vectors++; if ({cur_state, st_enter} !== {4'd2, 1'b1}) begin miscompares++; $display("FAIL game_timeout_100: got state=%0d st_enter=%0d want 2/1", cur_state, st_enter); end
    step(0, 0, 0);
    vectors++; if (credit !== 7'd3) begin miscompares++; $display("FAIL timeout_payout: got %0d want 3", credit); end
    step(0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if ({cur_state, credit, st_enter} !== {4'd0, 7'd0, 1'b0}) begin miscompares++; $display("FAIL mid_score_rst: got state=%0d credit=%0d st_enter=%0d want 0/0/0", cur_state, credit, st_enter); end
    rst = 1'b0;
    step(0, 0, 0);
    vectors++; if ({cur_state, credit, st_enter} !== {4'd0, 7'd0, 1'b0}) begin miscompares++; $display("FAIL after_rst: got state=%0d credit=%0d st_enter=%0d want 0/0/0", cur_state, credit, st_enter); end
  endtask

  task automatic test_scan;
    logic       exp_sign;
    logic [1:0] exp_ref;
    do_reset(2);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0);
      exp_sign = (k % SD == SD - 1);
      exp_ref  = 2'((k / SD) % 4);
      vectors++;
      if ({ref_sign, refresh} !== {exp_sign, exp_ref}) begin
        miscompares++;
        $display("FAIL scan_k%0d: got ref_sign=%0d refresh=%0d want %0d/%0d", k, ref_sign, refresh, exp_sign, exp_ref);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] e_st;
    logic [6:0] e_cr;
    logic       e_en, e_sign;
    logic [1:0] e_ref;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      coin   = ($urandom_range(0, 7) == 0);
      start  = ($urandom_range(0, 9) == 0);
      stop   = ($urandom_range(0, 11) == 0);
      payout = 4'($urandom_range(0, 15));
      @(posedge clk);
      @(negedge clk);
      e_st   = m.st;
      e_cr   = m.cr;
      e_en   = m.en;
      e_sign = (m_scan % SD == SD - 1);
      e_ref  = 2'((m_scan / SD) % 4);
      vectors++;
      if ({cur_state, credit, st_enter, ref_sign, refresh} !== {e_st, e_cr, e_en, e_sign, e_ref}) begin
        miscompares++;
        $display("FAIL random_c%0d: got st=%0d cr=%0d en=%0d sg=%0d rf=%0d want st=%0d cr=%0d en=%0d sg=%0d rf=%0d",
                 i, cur_state, credit, st_enter, ref_sign, refresh, e_st, e_cr, e_en, e_sign, e_ref);
      end
    end
    rst = 1'b0; coin = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_game_score();
    test_error();
    test_simultaneous();
    test_saturation();
    test_game_timeout_rst();
    test_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bandit_ctrl.md
BANDIT_CTRL -- requirements
Module: bandit_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: clk cycles per one-second tick.
REQ-002 Parameter SCAN_DIV, default 100_000: clk cycles per display-digit scan step.
REQ-003 Parameter GAME_MAX_S, default 10: seconds before GAME auto-stops.
REQ-004 Parameter SCORE_HOLD_S, default 3: seconds SCORE is held; ERR_HOLD_S, default 2: seconds ERROR is held.
REQ-005 Parameter CREDIT_MAX, default 99: credit saturation value.
REQ-006 clk  in  1  system clock; the block has one clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 coin  in  1  one-cycle coin-inserted pulse, already debounced.
REQ-009 start  in  1  one-cycle start-button pulse, already debounced.
REQ-010 stop  in  1  one-cycle stop-button pulse, already debounced.
REQ-011 payout  in  4  win amount from score logic, valid while cur_state==SCORE.
REQ-012 cur_state  out  4  WELCOME=0, GAME=1, SCORE=2, ERROR=3, COIN=4.
REQ-013 credit  out  7  current credit, 0..CREDIT_MAX.
REQ-014 refresh  out  2  display digit select, 0..3, wraps.
REQ-015 ref_sign  out  1  one-cycle scan strobe.
REQ-016 st_enter  out  1  one-cycle pulse on the first cycle of any new state.

Function
REQ-017 Every output SHALL be registered; control-input-to-cur_state latency SHALL be 1 clk.
REQ-018 WELCOME: coin -> COIN with credit+1; start with no coin -> ERROR; coin and start in the same cycle -> COIN only.
REQ-019 COIN: coin -> credit+1; start with credit>=1 -> GAME with credit-1; start with credit==0 -> ERROR; coin and start in the same cycle -> GAME with credit unchanged.
REQ-020 GAME: stop, or GAME_MAX_S seconds elapsed -> SCORE; coin/start SHALL be ignored.
REQ-021 SCORE: on the entry cycle (st_enter high) payout SHALL be added once to credit, saturating at CREDIT_MAX; after SCORE_HOLD_S seconds -> COIN if credit>0, else WELCOME.
REQ-022 ERROR: after ERR_HOLD_S seconds -> WELCOME; all buttons and coin SHALL be ignored.
REQ-023 Credit increment at CREDIT_MAX SHALL hold CREDIT_MAX; decrement never occurs at 0.
REQ-024 The second timer SHALL restart from 0 on every state entry; a hold of N seconds SHALL equal exactly N*CLK_HZ cycles after st_enter.
REQ-025 Undefined cur_state codes SHALL return to WELCOME on the next cycle.
REQ-026 The scan counter SHALL run in all states; ref_sign SHALL be high on count SCAN_DIV-1; refresh SHALL increment on the edge after ref_sign and stay stable while ref_sign is high.

Reset
REQ-027 While rst is high: cur_state=WELCOME, credit=0, refresh=0, ref_sign=0, st_enter=0, all counters=0.
REQ-028 rst mid-operation SHALL discard credit and any timer progress; the first cycle after rst deasserts SHALL be WELCOME with st_enter=0.

Configuration
REQ-029 Macro BANDIT_IDLE_RETURN_EN: when defined, COIN with no coin/start activity for 30 seconds SHALL go to WELCOME, keeping credit.
REQ-030 Without BANDIT_IDLE_RETURN_EN, COIN SHALL remain indefinitely until coin or start.

Structure
REQ-031 Shared package bandit_pkg SHALL hold the state encodings, STATE_W=4, CREDIT_W=7, and the default timing constants.
REQ-032 Sub-module sec_timer SHALL provide the one-second tick and seconds count, with synchronous clear on state entry.

Verification
REQ-033 CLK_HZ=10, rst 3 cycles, then coin -> cycle+1: cur_state=4, credit=1, st_enter=1.
REQ-034 In COIN with credit=1, start -> GAME, credit=0; stop -> SCORE; payout=5 -> credit=5; after 30 clks -> COIN.
REQ-035 WELCOME, start with no credit -> ERROR; coin during ERROR ignored (credit stays 0); after 20 clks -> WELCOME.
REQ-036 credit=99, coin -> credit stays 99; SCORE with payout=9 -> credit stays 99.
REQ-037 GAME with no stop, CLK_HZ=10 -> SCORE exactly 100 clks after entry; rst asserted mid-SCORE -> WELCOME, credit=0.
REQ-038 SCAN_DIV=4 -> ref_sign every 4th clk; refresh sequence 0,1,2,3,0, changing on the clk after each ref_sign.
